dmem_ctrl: RTL

//  Parametrised data-memory controller for the pipelined RISC-V core.

---
 rtl/dmem_ctrl_if.sv | 33 +++
 rtl/dmem_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage and the data-memory controller.
//   req_valid/req_ready : request handshake (accept = valid & ready)
//   req_we/req_funct3   : store flag and RISC-V funct3 (size/sign)
//   req_addr/req_wdata  : byte address and store data
//   rsp_valid           : one-cycle completion pulse
//   rsp_rdata/rsp_err   : load result / misaligned-or-unsupported flag
//   stall               : combinational hold for the MEM stage
interface dmem_ctrl_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;
    logic            stall;

    // Pipeline (MEM stage) side
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );

    // Controller side
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, stall
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32I pipeline: LB/LH/LW/LBU/LHU/SB/SH/SW
// with a fixed access latency, valid/ready handshake and MEM-stage stall.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (memory contents are kept)
//   bus   : dmem_ctrl_if slave modport (request, response, stall)
module dmem_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 2
) (
    input  logic         clk,
    input  logic         reset,
    dmem_ctrl_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(LATENCY + 1);
    localparam int unsigned NB = XLEN / 8;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [XLEN-1:0] mem_q [DEPTH_WORDS];

    // Access captured at acceptance, consumed when the response is formed
    logic [XLEN-1:0] word_q;
    logic [2:0]      f3_q;
    logic [1:0]      off_q;
    logic            we_q;
    logic            err_q;

    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_rdata_q;
    logic            rsp_err_q;

    logic            accept;
    logic [AW-1:0]   idx;
    logic [1:0]      off;
    logic            req_err;
    logic [NB-1:0]   be;
    logic [XLEN-1:0] wdata_rep;

    logic            src_live;
    logic [XLEN-1:0] src_word;
    logic [2:0]      src_f3;
    logic [1:0]      src_off;
    logic            src_we;
    logic            src_err;
    logic [XLEN-1:0] rdata_d;

    // Address bits above the word index are ignored so the array wraps
    logic            unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[XLEN-1:AW+2];

    function automatic logic access_err(input logic [2:0] f3, input logic [1:0] o);
        case (f3)
            3'd0, 3'd4: access_err = 1'b0;
            3'd1, 3'd5: access_err = o[0];
            3'd2:       access_err = (o != 2'b00);
            default:    access_err = 1'b1;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] w,
                                                    input logic [2:0] f3,
                                                    input logic [1:0] o);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    load_extend = {{(XLEN-8){b[7]}}, b};
            3'd1:    load_extend = {{(XLEN-16){h[15]}}, h};
            3'd2:    load_extend = w;
            3'd4:    load_extend = {{(XLEN-8){1'b0}}, b};
            3'd5:    load_extend = {{(XLEN-16){1'b0}}, h};
            default: load_extend = '0;
        endcase
    endfunction

    // Handshake and stall
    assign bus.req_ready = (state_q != BUSY);
    assign accept        = bus.req_valid & bus.req_ready;
    // Equivalent to (valid & !BUSY & !(RESP & !valid)) | BUSY
    assign bus.stall     = (bus.req_valid & (state_q != BUSY)) | (state_q == BUSY);

    assign idx     = bus.req_addr[AW+1:2];
    assign off     = bus.req_addr[1:0];
    assign req_err = access_err(bus.req_funct3, off);

    // Store byte enables and lane-replicated write data
    always_comb begin
        be        = 4'b1111;
        wdata_rep = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'd0: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                be        = off[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = bus.req_wdata;
            end
        endcase
    end

    // Response source: live request when LATENCY==1 completes straight from
    // IDLE/RESP, captured access when leaving BUSY
    always_comb begin
        src_live = (state_q != BUSY);
        src_word = src_live ? mem_q[idx]      : word_q;
        src_f3   = src_live ? bus.req_funct3  : f3_q;
        src_off  = src_live ? off             : off_q;
        src_we   = src_live ? bus.req_we      : we_q;
        src_err  = src_live ? req_err         : err_q;
        rdata_d  = (src_err | src_we) ? '0 : load_extend(src_word, src_f3, src_off);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CW'(LATENCY - 1);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, capture and registered response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            f3_q        <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= (state_d == RESP);
            rsp_rdata_q <= (state_d == RESP) ? rdata_d : '0;
            rsp_err_q   <= (state_d == RESP) & src_err;
            if (accept) begin
                word_q <= mem_q[idx];
                f3_q   <= bus.req_funct3;
                off_q  <= off;
                we_q   <= bus.req_we;
                err_q  <= req_err;
            end
        end
    end

    // Storage array; legal stores commit on the acceptance edge
    always_ff @(posedge clk) begin
        if (accept && bus.req_we && !req_err && !reset) begin
            for (int b = 0; b < NB; b++) begin
                if (be[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
